serializer: RTL and testbench
=============================

Name: serializer

Overview:
- Transmit end of the team's serial link: takes a parallel word over a valid/ready handshake and shifts it out MSB first.
- Generates the bit strobe (enable_o) and first-bit marker (start_o) the link's deserializer consumes on enable_i/start_i.
- Optional Hamming check bits are appended after the data, so a receiver built with HAS_ECC=1 can correct single-bit faults.
- Bit rate is set by an internal clock divider.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=2).
HAS_ECC, 0, 1 = append CODE_BITS Hamming check bits after the data.
CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); enable_o pulses once per bit.

Ports:
clk_i  input  1  clock, all logic on rising edge.
rst_i  input  1  reset; asynchronous assert, active-high.
data_i  input  DATA_WIDTH  parallel word to send.
valid_i  input  1  data_i valid.
ready_o  output  1  block can accept a word.
serial_out_o  output  1  serial data.
enable_o  output  1  bit strobe; receiver samples serial_out_o on the edge ending this cycle.
start_o  output  1  high with enable_o on the first bit of a frame.
busy_o  output  1  frame in progress.

Behaviour:
- Reset is asynchronous and active-high; one clock (clk_i).
- While rst_i is high: state=IDLE, all counters and the shift register are 0, serial_out_o=0, enable_o=0, start_o=0, busy_o=0.
- After reset release: ready_o=1.
- Frame width and derived constants:
  - CODE_BITS = smallest r with 2^r >= DATA_WIDTH+r+1.
  - FRAME_WIDTH = DATA_WIDTH when HAS_ECC=0, else DATA_WIDTH+CODE_BITS.
  - Bit counter width: $clog2(FRAME_WIDTH+1). Divider width: max(1,$clog2(CLKS_PER_BIT)).
- ECC parity, for HAS_ECC=1:
  - Codeword positions run 1..FRAME_WIDTH.
  - Data bits occupy the non-power-of-two positions in ascending order, with data_i[0] at the lowest such position.
  - Check bit p[k] = XOR of all data bits whose position has bit k set.
  - Parity is computed combinationally from data_i and captured at accept.
- Frame bit order: data_i[DATA_WIDTH-1] down to data_i[0], then (ECC only) p[CODE_BITS-1] down to p[0].
- FSM states: IDLE and SEND.
- IDLE:
  - ready_o=1, busy_o=0, serial_out_o=0.
  - On a rising edge with valid_i=1: load the shift register with the frame (first bit in MSB), clear the divider and bit counter, go to SEND.
- SEND:
  - ready_o=0, busy_o=1, serial_out_o = shift register MSB (held stable for the whole bit).
  - The divider counts 0..CLKS_PER_BIT-1.
  - In the cycle where divider == CLKS_PER_BIT-1: enable_o=1, and start_o=1 iff bit counter == 0.
  - At the end of that cycle: shift left, increment the bit counter, wrap the divider to 0.
  - After the FRAME_WIDTH-th strobe, return to IDLE.
- Latency and throughput:
  - The first strobe falls in the CLKS_PER_BIT-th cycle after the accept edge.
  - ready_o rises in the cycle after the last strobe.
  - Words are sent every FRAME_WIDTH*CLKS_PER_BIT+1 cycles at most.
- Boundary conditions:
  - valid_i held during SEND: ignored, and data_i is not re-sampled.
  - data_i changing after accept does not affect the frame.
  - With CLKS_PER_BIT=1, enable_o is high every SEND cycle.
  - rst_i asserted mid-frame: the frame is abandoned immediately, outputs take reset values, and no partial strobe occurs.
  - enable_o, start_o and serial_out_o are decoded from registered state only (no combinational path from data_i or valid_i).

Test Plan:
- Basic frame: DATA_WIDTH=8, HAS_ECC=0, CLKS_PER_BIT=1, accept 8'hA5.
  -> 8 consecutive enable_o cycles carrying 1,0,1,0,0,1,0,1; start_o only on the first; ready_o=1 in the cycle after the 8th; a loop-back deserializer outputs 8'hA5.
- ECC frame: DATA_WIDTH=4, HAS_ECC=1 (CODE_BITS=3), accept 4'b1011.
  -> 7 strobes carrying 1,0,1,1,0,0,1 (p2=0, p1=0, p0=1); the receiver decodes 4'b1011 with zero errors.
- Divider: CLKS_PER_BIT=4, accept at edge T0.
  -> enable_o in cycles T0+4, T0+8, ... T0+32 for 8 bits; serial_out_o stable across each 4-cycle bit; busy_o high from T0+1 to T0+32.
- Back-pressure: valid_i held high with 8'h3C then 8'hC3.
  -> the second word is accepted only when ready_o returns; 8'h3C is sent unchanged despite data_i changing; output shows 00111100 then 11000011.
- Reset mid-frame: assert rst_i asynchronously after the 3rd strobe of 8'hFF.
  -> outputs drop to 0 without waiting for a clock edge, no further strobes, ready_o=1 after release; the next word 8'h01 is sent correctly with start_o on its first bit.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial link transmitter: MSB-first frame with optional Hamming check bits, plus bit strobe and first-bit marker.
// Latency: first strobe lands CLKS_PER_BIT cycles after the accept edge; a frame occupies FRAME_WIDTH*CLKS_PER_BIT cycles.
// Backpressure: ready_o is high only in IDLE; valid_i and data_i are ignored for the whole frame.
module serializer #(
   parameter int DATA_WIDTH   = 8,
   parameter int HAS_ECC      = 0,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic                  serial_out_o,
   output logic                  enable_o,
   output logic                  start_o,
   output logic                  busy_o
);

   // Smallest r with 2^r >= DATA_WIDTH + r + 1 (Hamming check-bit count).
   function automatic int calc_code_bits(input int dw);
      int r;
      r = 1;
      while ((1 << r) < dw + r + 1) r++;
      return r;
   endfunction

   localparam int CODE_BITS   = calc_code_bits(DATA_WIDTH);
   localparam int FRAME_WIDTH = (HAS_ECC != 0) ? DATA_WIDTH + CODE_BITS : DATA_WIDTH;
   localparam int CNT_W       = $clog2(FRAME_WIDTH + 1);
   localparam int DIV_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WIDTH - 1);

   // Data bits fill the non-power-of-two codeword positions (1-based) in
   // ascending order starting with d[0]; check bit k covers every position
   // whose index has bit k set.
   function automatic logic [CODE_BITS-1:0] calc_parity(input logic [DATA_WIDTH-1:0] d);
      logic [CODE_BITS-1:0] p;
      int                   di;
      p  = '0;
      di = 0;
      for (int pos = 3; pos <= DATA_WIDTH + CODE_BITS; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            for (int k = 0; k < CODE_BITS; k++) begin
               if (((pos >> k) & 1) != 0) p[k] = p[k] ^ d[di];
            end
            di++;
         end
      end
      return p;
   endfunction

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state;
   logic [FRAME_WIDTH-1:0] frame;
   logic [FRAME_WIDTH-1:0] shift_q;
   logic [DIV_W-1:0]       div_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   strobe;

   // Frame layout: data MSB first, check bits (high to low) trailing.
   generate
      if (HAS_ECC != 0) begin : g_ecc
         assign frame = {data_i, calc_parity(data_i)};
      end else begin : g_plain
         assign frame = data_i;
      end
   endgenerate

   // Last divider cycle of a bit is the one the receiver samples on.
   assign strobe = (state == SEND) && (div_q == DIV_LAST);

   // Accept in IDLE, then pace the shift register out one bit per divider period.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         shift_q <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  shift_q <= frame;
                  div_q   <= '0;
                  cnt_q   <= '0;
                  state   <= SEND;
               end
            end
            SEND: begin
               if (div_q == DIV_LAST) begin
                  div_q   <= '0;
                  shift_q <= {shift_q[FRAME_WIDTH-2:0], 1'b0};
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) state <= IDLE;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // All outputs decode registered state only, so reset clears them at once.
   assign ready_o      = (state == IDLE);
   assign busy_o       = (state == SEND);
   assign serial_out_o = (state == SEND) && shift_q[FRAME_WIDTH-1];
   assign enable_o     = strobe;
   assign start_o      = strobe && (cnt_q == '0);

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A: 8 data bits, no ECC, one clock per bit.
   logic [7:0] a_dat;
   logic       a_vld, a_rdy, a_ser, a_en, a_st, a_busy;
   // Instance B: 4 data bits, Hamming check bits, one clock per bit.
   logic [3:0] b_dat;
   logic       b_vld, b_rdy, b_ser, b_en, b_st, b_busy;
   // Instance C: 8 data bits, no ECC, four clocks per bit.
   logic [7:0] c_dat;
   logic       c_vld, c_rdy, c_ser, c_en, c_st, c_busy;

   serializer #(.DATA_WIDTH(8), .HAS_ECC(0), .CLKS_PER_BIT(1)) u_a (
      .clk_i(clk), .rst_i(rst), .data_i(a_dat), .valid_i(a_vld), .ready_o(a_rdy),
      .serial_out_o(a_ser), .enable_o(a_en), .start_o(a_st), .busy_o(a_busy));
   serializer #(.DATA_WIDTH(4), .HAS_ECC(1), .CLKS_PER_BIT(1)) u_b (
      .clk_i(clk), .rst_i(rst), .data_i(b_dat), .valid_i(b_vld), .ready_o(b_rdy),
      .serial_out_o(b_ser), .enable_o(b_en), .start_o(b_st), .busy_o(b_busy));
   serializer #(.DATA_WIDTH(8), .HAS_ECC(0), .CLKS_PER_BIT(4)) u_c (
      .clk_i(clk), .rst_i(rst), .data_i(c_dat), .valid_i(c_vld), .ready_o(c_rdy),
      .serial_out_o(c_ser), .enable_o(c_en), .start_o(c_st), .busy_o(c_busy));

   int total = 0;
   int bad   = 0;

   // Expected strobes as {start, bit}, and expected received words.
   logic [1:0] qa[$];
   logic [1:0] qb[$];
   logic [1:0] qc[$];
   logic [7:0] wa[$];
   logic [3:0] wb[$];
   logic [7:0] wc[$];

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%b want=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: event not expected / did not occur t=%0t", nm, $time);
   endtask

   // Reference Hamming(7,4): codeword positions 1..7, check bits at 1,2,4.
   function automatic logic [2:0] ham_par(input logic [3:0] w);
      logic [7:1] cw;
      logic [2:0] p;
      int         j;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos <= 7; pos++) begin
         if (pos != 1 && pos != 2 && pos != 4) begin
            cw[pos] = w[j];
            j++;
         end
      end
      p = '0;
      for (int k = 0; k < 3; k++)
         for (int pos = 1; pos <= 7; pos++)
            if (((pos >> k) & 1) == 1) p[k] = p[k] ^ cw[pos];
      return p;
   endfunction

   // Receiver-side syndrome of a received frame {d3,d2,d1,d0,p2,p1,p0}.
   function automatic logic [7:0] ham_syn(input logic [6:0] f);
      logic [7:1] cw;
      logic [7:0] s;
      cw = {f[6], f[5], f[4], f[2], f[3], f[1], f[0]};
      s  = '0;
      for (int pos = 1; pos <= 7; pos++)
         if (cw[pos]) s = s ^ 8'(pos);
      return s;
   endfunction

   task automatic send_a(input logic [7:0] w, input bit hold);
      int t;
      t = 0;
      @(negedge clk);
      a_dat = w;
      a_vld = 1'b1;
      while (a_rdy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (a_rdy !== 1'b1) begin fail("a_accept_timeout"); a_vld = 1'b0; return; end
      @(posedge clk);
      for (int i = 7; i >= 0; i--) qa.push_back({i == 7, w[i]});
      wa.push_back(w);
      #1;
      a_dat = 8'($urandom);
      a_vld = hold;
   endtask

   task automatic send_b(input logic [3:0] w, input bit hold);
      int         t;
      logic [2:0] p;
      t = 0;
      @(negedge clk);
      b_dat = w;
      b_vld = 1'b1;
      while (b_rdy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (b_rdy !== 1'b1) begin fail("b_accept_timeout"); b_vld = 1'b0; return; end
      @(posedge clk);
      p = ham_par(w);
      for (int i = 3; i >= 0; i--) qb.push_back({i == 3, w[i]});
      for (int k = 2; k >= 0; k--) qb.push_back({1'b0, p[k]});
      wb.push_back(w);
      #1;
      b_dat = 4'($urandom);
      b_vld = hold;
   endtask

   task automatic send_c(input logic [7:0] w, input bit hold);
      int t;
      t = 0;
      @(negedge clk);
      c_dat = w;
      c_vld = 1'b1;
      while (c_rdy !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      if (c_rdy !== 1'b1) begin fail("c_accept_timeout"); c_vld = 1'b0; return; end
      @(posedge clk);
      for (int i = 7; i >= 0; i--) qc.push_back({i == 7, w[i]});
      wc.push_back(w);
      #1;
      c_dat = 8'($urandom);
      c_vld = hold;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((qa.size() != 0 || qb.size() != 0 || qc.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) fail("drain_timeout");
   endtask

   // Monitor A: scoreboard pop on each strobe plus a loop-back word assembler.
   logic [7:0] ra;
   int         na = 0;
   always @(negedge clk) begin : mon_a
      logic [1:0] e;
      chk1("a_ready_vs_busy", a_rdy, !a_busy);
      if (rst) na = 0;
      else if (a_en === 1'b1) begin
         if (qa.size() == 0) fail("a_extra_strobe");
         else begin
            e = qa.pop_front();
            chk1("a_bit", a_ser, e[0]);
            chk1("a_start", a_st, e[1]);
         end
         if (a_st === 1'b1) na = 0;
         ra = {ra[6:0], a_ser};
         na++;
         if (na == 8) begin
            na = 0;
            if (wa.size() == 0) fail("a_extra_word");
            else chk8("a_rx_word", ra, wa.pop_front());
         end
      end else chk1("a_start_without_en", a_st, 1'b0);
   end

   // Monitor B: scoreboard pop plus receiver-side Hamming decode.
   logic [6:0] rb;
   int         nb = 0;
   always @(negedge clk) begin : mon_b
      logic [1:0] e;
      chk1("b_ready_vs_busy", b_rdy, !b_busy);
      if (rst) nb = 0;
      else if (b_en === 1'b1) begin
         if (qb.size() == 0) fail("b_extra_strobe");
         else begin
            e = qb.pop_front();
            chk1("b_bit", b_ser, e[0]);
            chk1("b_start", b_st, e[1]);
         end
         if (b_st === 1'b1) nb = 0;
         rb = {rb[5:0], b_ser};
         nb++;
         if (nb == 7) begin
            nb = 0;
            chk8("b_syndrome", ham_syn(rb), 8'h00);
            if (wb.size() == 0) fail("b_extra_word");
            else chk8("b_rx_word", {4'b0, rb[6:3]}, {4'b0, wb.pop_front()});
         end
      end else chk1("b_start_without_en", b_st, 1'b0);
   end

   // Monitor C: scoreboard pop plus loop-back word assembler.
   logic [7:0] rc;
   int         nc = 0;
   always @(negedge clk) begin : mon_c
      logic [1:0] e;
      chk1("c_ready_vs_busy", c_rdy, !c_busy);
      if (rst) nc = 0;
      else if (c_en === 1'b1) begin
         if (qc.size() == 0) fail("c_extra_strobe");
         else begin
            e = qc.pop_front();
            chk1("c_bit", c_ser, e[0]);
            chk1("c_start", c_st, e[1]);
         end
         if (c_st === 1'b1) nc = 0;
         rc = {rc[6:0], c_ser};
         nc++;
         if (nc == 8) begin
            nc = 0;
            if (wc.size() == 0) fail("c_extra_word");
            else chk8("c_rx_word", rc, wc.pop_front());
         end
      end else chk1("c_start_without_en", c_st, 1'b0);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] pat;
      logic [6:0] epat;
      logic       held;
      int         n, t;

      a_dat = '0; a_vld = 1'b0;
      b_dat = '0; b_vld = 1'b0;
      c_dat = '0; c_vld = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk1("rst_a_ser", a_ser, 1'b0);
      chk1("rst_a_en", a_en, 1'b0);
      chk1("rst_a_start", a_st, 1'b0);
      chk1("rst_a_busy", a_busy, 1'b0);
      chk1("rst_b_busy", b_busy, 1'b0);
      chk1("rst_c_busy", c_busy, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_a_ready", a_rdy, 1'b1);
      chk1("post_rst_b_ready", b_rdy, 1'b1);
      chk1("post_rst_c_ready", c_rdy, 1'b1);

      // Basic frame 8'hA5
      pat = 8'hA5;
      send_a(pat, 1'b0);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i <= 8) begin
            chk1("basic_en", a_en, 1'b1);
            chk1("basic_bit", a_ser, pat[8-i]);
            chk1("basic_start", a_st, i == 1);
         end else begin
            chk1("basic_ready_after", a_rdy, 1'b1);
            chk1("basic_en_after", a_en, 1'b0);
         end
      end

      // ECC frame 4'b1011 -> 1,0,1,1,0,0,1
      epat = 7'b1011001;
      send_b(4'b1011, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i <= 7) begin
            chk1("ecc_en", b_en, 1'b1);
            chk1("ecc_bit", b_ser, epat[7-i]);
         end else begin
            chk1("ecc_ready_after", b_rdy, 1'b1);
         end
      end

      // Divider: strobes at T0+4k, bit stable across 4 cycles, busy T0+1..T0+32
      held = 1'b0;
      send_c(8'h96, 1'b0);
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         chk1("div_en", c_en, (i % 4 == 0) && (i <= 32));
         chk1("div_busy", c_busy, i <= 32);
         if (i <= 32) begin
            if (i % 4 == 1) held = c_ser;
            else chk1("div_bit_stable", c_ser, held);
         end
      end

      // Back-pressure: valid held, data changes right after accept
      send_a(8'h3C, 1'b1);
      send_a(8'hC3, 1'b0);
      drain();

      // Reset mid-frame after the 3rd strobe of 8'hFF
      send_a(8'hFF, 1'b0);
      n = 0;
      t = 0;
      while (n < 3 && t < 50) begin
         @(negedge clk);
         if (a_en === 1'b1) n++;
         t++;
      end
      if (n < 3) fail("rst_mid_strobes_seen");
      @(posedge clk);
      #2;
      chk1("rst_mid_busy_before", a_busy, 1'b1);
      rst = 1'b1;
      qa.delete();
      wa.delete();
      #1;
      chk1("rst_mid_ser", a_ser, 1'b0);
      chk1("rst_mid_en", a_en, 1'b0);
      chk1("rst_mid_start", a_st, 1'b0);
      chk1("rst_mid_busy", a_busy, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk1("rst_hold_en", a_en, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk1("rst_release_ready", a_rdy, 1'b1);
      send_a(8'h01, 1'b0);
      drain();

      // Randomized traffic on all three instances concurrently
      fork
         begin : rnd_a
            bit h;
            bit hp;
            hp = 1'b0;
            for (int k = 0; k < 20; k++) begin
               if (!hp) repeat ($urandom_range(0, 3)) @(negedge clk);
               h = (k < 19) && ($urandom_range(0, 1) == 1);
               send_a(8'($urandom), h);
               hp = h;
            end
         end
         begin : rnd_b
            bit h;
            bit hp;
            hp = 1'b0;
            for (int k = 0; k < 20; k++) begin
               if (!hp) repeat ($urandom_range(0, 3)) @(negedge clk);
               h = (k < 19) && ($urandom_range(0, 1) == 1);
               send_b(4'($urandom), h);
               hp = h;
            end
         end
         begin : rnd_c
            bit h;
            bit hp;
            hp = 1'b0;
            for (int k = 0; k < 12; k++) begin
               if (!hp) repeat ($urandom_range(0, 3)) @(negedge clk);
               h = (k < 11) && ($urandom_range(0, 1) == 1);
               send_c(8'($urandom), h);
               hp = h;
            end
         end
      join
      drain();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
